// File: rtl/vedic_div_16by8_pkg.sv
// ---------------------------------------------------------------------------
// vedic_div_16by8_pkg
//  Shared definitions for the 16/8 restoring divider:
//   - VEDIC_W    : default divisor/quotient/remainder width
//   - state_e    : divider FSM state encoding
//   - all_ones() : saturated quotient value returned on div_zero/ovf
// ---------------------------------------------------------------------------
package vedic_div_16by8_pkg;

   localparam int VEDIC_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic [VEDIC_W-1:0] all_ones();
      return '1;
   endfunction

endpackage

// File: rtl/vedic_div_16by8_if.sv
// ---------------------------------------------------------------------------
// vedic_div_16by8_if
//  Operand/result handshake bundle for the divider.
//   in_valid/in_ready   : operand pair handshake (dividend 2W, divisor W)
//   out_valid/out_ready : result handshake (quotient, remainder, div_zero, ovf)
//  Modports:
//   master : producer/consumer side (testbench or surrounding datapath)
//   slave  : divider side
// ---------------------------------------------------------------------------
interface vedic_div_16by8_if
   import vedic_div_16by8_pkg::*;
#(
   parameter int W = VEDIC_W
);
   logic           in_valid;
   logic           in_ready;
   logic [2*W-1:0] dividend;
   logic [W-1:0]   divisor;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           div_zero;
   logic           ovf;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero, ovf
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero, ovf
   );
endinterface

// File: rtl/vedic_div_16by8_step.sv
// ---------------------------------------------------------------------------
// vedic_div_step
//  One combinational restoring-division step.
//   p_i      : W-bit partial remainder
//   bit_i    : next dividend bit shifted into the partial remainder
//   divisor_i: W-bit divisor
//   p_o      : new partial remainder
//   qbit_o   : quotient bit produced by this step
// ---------------------------------------------------------------------------
module vedic_div_step
   import vedic_div_16by8_pkg::*;
#(
   parameter int W = VEDIC_W
) (
   input  logic [W-1:0] p_i,
   input  logic         bit_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] p_o,
   output logic         qbit_o
);
   logic [W:0]   t;
   logic [W-1:0] diff;

   assign t      = {p_i, bit_i};
   assign qbit_o = (t >= {1'b0, divisor_i});
   // When t >= divisor the true difference is < divisor, so it fits in W bits;
   // the W-bit modular subtraction yields exactly those low bits.
   assign diff   = t[W-1:0] - divisor_i;
   assign p_o    = qbit_o ? diff : t[W-1:0];
endmodule

// File: rtl/vedic_div_16by8.sv
// ---------------------------------------------------------------------------
// vedic_div_16by8
//  Sequential radix-2 restoring divider, 2W-bit dividend / W-bit divisor,
//  one quotient bit per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (aborts any operation in flight)
//   bus : slave side of vedic_div_16by8_if
//         in_valid/in_ready/dividend/divisor     operand handshake
//         out_valid/out_ready/quotient/remainder result handshake
//         div_zero/ovf                           result flags
// ---------------------------------------------------------------------------
module vedic_div_16by8
   import vedic_div_16by8_pkg::*;
#(
   parameter int W = VEDIC_W
) (
   input logic              clk,
   input logic              rst,
   vedic_div_16by8_if.slave bus
);
   localparam int CNT_W = $clog2(W);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     p_q;       // partial remainder, final remainder in DONE
   logic [W-1:0]     q_q;       // dividend low half shifting out, quotient shifting in
   logic [W-1:0]     div_q;
   logic             dz_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [W-1:0]     step_p;
   logic             step_qbit;
   logic [W-1:0]     hi;
   logic [W-1:0]     lo;

   assign hi = bus.dividend[2*W-1:W];
   assign lo = bus.dividend[W-1:0];

   vedic_div_step #(.W(W)) u_step (
      .p_i       (p_q),
      .bit_i     (q_q[W-1]),
      .divisor_i (div_q),
      .p_o       (step_p),
      .qbit_o    (step_qbit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         p_q         <= '0;
         q_q         <= '0;
         div_q       <= '0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  div_q      <= bus.divisor;
                  dz_q       <= 1'b0;
                  ovf_q      <= 1'b0;
                  in_ready_q <= 1'b0;
                  if (bus.divisor == '0) begin
                     dz_q        <= 1'b1;
                     q_q         <= all_ones();
                     p_q         <= lo;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else if (hi >= bus.divisor) begin
                     // Quotient would need more than W bits; this pre-check
                     // also keeps the W-bit partial remainder from overflowing.
                     ovf_q       <= 1'b1;
                     q_q         <= all_ones();
                     p_q         <= lo;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     cnt_q   <= CNT_W'(W-1);
                     p_q     <= hi;
                     q_q     <= lo;
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               p_q <= step_p;
               q_q <= {q_q[W-2:0], step_qbit};
               if (cnt_q == '0) begin
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.quotient  = q_q;
   assign bus.remainder = p_q;
   assign bus.div_zero  = dz_q;
   assign bus.ovf       = ovf_q;
endmodule
